// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data ports.
// Optional memory-ready watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic                  if_valid_o,
  output logic [31:0]           if_rdata_o,
  input  logic                  dm_req_i,
  input  logic                  dm_we_i,
  input  logic [ADDR_WIDTH-1:0] dm_addr_i,
  input  logic [31:0]           dm_wdata_i,
  input  logic [3:0]            dm_be_i,
  output logic                  dm_valid_o,
  output logic [31:0]           dm_rdata_o,
  output logic                  stall_if_o,
  output logic                  stall_mem_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  output logic [3:0]            mem_be_o,
  input  logic                  mem_ready_i,
  input  logic [31:0]           mem_rdata_i,
  output logic                  bus_err_o
);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve_limit
    $error("STARVE_LIMIT must be within 1..15");
  end
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 1024) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be within 2..1024");
  end

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_we;
  logic [31:0]           r_wdata;
  logic [3:0]            r_be;
  logic [3:0]            r_starve_cnt;

  logic w_busy;
  logic w_grant_if;
  logic w_grant_dm;
  logic w_abort;
  logic w_done;

  assign w_busy     = (r_state != IDLE);
  // Data wins a tie unless fetch has already been passed over STARVE_LIMIT times.
  assign w_grant_if = (r_state == IDLE) && if_req_i &&
                      (!dm_req_i || r_starve_cnt == 4'(STARVE_LIMIT));
  assign w_grant_dm = (r_state == IDLE) && dm_req_i && !w_grant_if;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES);
  logic [WAIT_W-1:0] r_wait_cnt;

  // Held at zero in IDLE, so every access starts counting from zero.
  always_ff @(posedge clk_i) begin
    if (!reset_i)          r_wait_cnt <= '0;
    else if (!w_busy)      r_wait_cnt <= '0;
    else if (!mem_ready_i) r_wait_cnt <= r_wait_cnt + 1'b1;
  end

  assign w_abort   = w_busy && !mem_ready_i && (r_wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));
  assign bus_err_o = w_abort;
`else
  assign w_abort   = 1'b0;
  assign bus_err_o = 1'b0;
`endif

  assign w_done = w_busy && (mem_ready_i || w_abort);

  // NOTE: reset_i is only sampled on the clock edge; it is not in the sensitivity list.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      r_state      <= IDLE;
      r_addr       <= '0;
      r_we         <= 1'b0;
      r_wdata      <= '0;
      r_be         <= '0;
      r_starve_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (r_state)
        IDLE: begin
          if (w_grant_if) begin
            r_state <= BUSY_IF;
            r_addr  <= if_addr_i;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_be    <= 4'hF;
          end else if (w_grant_dm) begin
            r_state <= BUSY_DM;
            r_addr  <= dm_addr_i;
            r_we    <= dm_we_i;
            r_wdata <= dm_wdata_i;
            r_be    <= dm_be_i;
          end
        end
        BUSY_IF, BUSY_DM: if (w_done) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase

      if (!if_req_i || w_grant_if)
        r_starve_cnt <= '0;
      else if (w_grant_dm && r_starve_cnt != 4'(STARVE_LIMIT))
        r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end

  assign mem_req_o   = w_busy;
  assign mem_we_o    = w_busy & r_we;
  assign mem_addr_o  = w_busy ? r_addr  : '0;
  assign mem_wdata_o = w_busy ? r_wdata : '0;
  assign mem_be_o    = w_busy ? r_be    : '0;

  assign if_valid_o  = (r_state == BUSY_IF) && w_done;
  assign dm_valid_o  = (r_state == BUSY_DM) && w_done;
  // An aborted access returns zero data; stores never return data.
  assign if_rdata_o  = (if_valid_o && mem_ready_i) ? mem_rdata_i : '0;
  assign dm_rdata_o  = (dm_valid_o && mem_ready_i && !r_we) ? mem_rdata_i : '0;

  assign stall_if_o  = if_req_i & ~if_valid_o;
  assign stall_mem_o = dm_req_i & ~dm_valid_o;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between two requesters: the instruction fetch port and the memory-stage data port (load/store).
- Sequences each access with a req/ready handshake on the memory side.
- Generates the stall_if/stall_mem signals that hold the fetch and memory pipeline registers until the access completes.
- Uses fixed data-over-fetch priority with a starvation guard for fetch.

Parameters:
- ADDR_WIDTH, 32, byte address width on all ports.
- STARVE_LIMIT, 4, consecutive data grants allowed while fetch waits; the next grant is forced to fetch (range 1-15).
- TIMEOUT_CYCLES, 256, memory-ready watchdog limit; used only with the optional feature (range 2-1024).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-low reset.
- if_req_i  in  1  fetch request; held high until if_valid_o.
- if_addr_i  in  ADDR_WIDTH  fetch address.
- if_valid_o  out  1  fetch access complete; one-cycle pulse.
- if_rdata_o  out  32  fetched word; valid only with if_valid_o, else 0.
- dm_req_i  in  1  data request; held high until dm_valid_o.
- dm_we_i  in  1  1 = store, 0 = load.
- dm_addr_i  in  ADDR_WIDTH  data address.
- dm_wdata_i  in  32  store data.
- dm_be_i  in  4  store byte enables.
- dm_valid_o  out  1  data access complete; one-cycle pulse.
- dm_rdata_o  out  32  load word; valid only with dm_valid_o, else 0.
- stall_if_o  out  1  equals if_req_i & ~if_valid_o.
- stall_mem_o  out  1  equals dm_req_i & ~dm_valid_o.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  memory write enable.
- mem_addr_o  out  ADDR_WIDTH  memory address.
- mem_wdata_o  out  32  memory write data.
- mem_be_o  out  4  memory byte enables.
- mem_ready_i  in  1  memory completes the access this cycle; rdata valid this cycle.
- mem_rdata_i  in  32  memory read data.
- bus_err_o  out  1  timeout abort pulse.

Behaviour:
- FSM states: IDLE, BUSY_IF, BUSY_DM. Reset (reset_i=0 at a clock edge) gives IDLE.
- All registered outputs and captured fields reset to 0. The starvation counter resets to 0.
- IDLE grant rules:
  - No request: stay in IDLE.
  - If both requests are present: grant DM unless starve_cnt == STARVE_LIMIT, in which case grant IF.
  - If only one request is present, grant it.
  - On a grant, capture the winner's addr/we/wdata/be into registers and move to BUSY_x. Fetch captures we=0, be=4'hF, wdata=0.
- BUSY_x:
  - mem_req_o=1. mem_* are driven only from the captured registers and are stable for the whole access.
  - When mem_ready_i=1, pulse x_valid_o combinationally that cycle, drive x_rdata_o = mem_rdata_i (0 for stores), and return to IDLE.
- Every access therefore has one IDLE bubble. Minimum latency is request in cycle N, mem_req_o in N+1, valid in N+1 if mem_ready_i is high then.
- mem_req_o=0 and mem_* = 0 in IDLE.
- Starvation counter:
  - Increments on a DM grant while if_req_i=1, saturating at STARVE_LIMIT.
  - Clears on an IF grant, and clears in any cycle with if_req_i=0.
- Request drop: a requester dropping req while in BUSY is a protocol violation. The access still completes and the valid pulse is still emitted.
- Stall outputs are combinational from req/valid, so stall falls in the completion cycle and the pipeline register advances at that edge.
- Simultaneous events: mem_ready_i in IDLE is ignored. Requests arriving in the completion cycle are arbitrated in the following IDLE cycle.
- Reset mid-access: the FSM goes to IDLE and mem_req_o drops the next cycle. No valid pulse is issued for the abandoned access, and the memory must discard it.

Optional Feature:
MEM_ARB_TIMEOUT_EN
- Defined:
  - A wait counter clears on entering BUSY and increments each BUSY cycle with mem_ready_i=0.
  - When it reaches TIMEOUT_CYCLES-1 without ready, the access aborts that cycle.
  - On abort: x_valid_o=1, x_rdata_o=0, bus_err_o=1 for one cycle, and the FSM returns to IDLE.
  - mem_ready_i arriving in the same cycle takes precedence: normal completion, no error.
- Undefined: the arbiter waits indefinitely, no wait counter is built, and bus_err_o is tied 0.

Test Plan:
- Single load: dm_req_i=1, dm_addr_i=0x100, ready on the first BUSY cycle with rdata 0xDEADBEEF -> mem_req_o high in cycle 1, dm_valid_o and dm_rdata_o=0xDEADBEEF in cycle 1, stall_mem_o high in cycle 0 only.
- Contention: if_req_i and dm_req_i both held, memory always ready, STARVE_LIMIT=4 -> grant order DM,DM,DM,DM,IF,DM,...; if_valid_o first pulses on the 5th access.
- Store: dm_we_i=1, addr 0x20, wdata 0x12345678, be 4'b0011, ready after 3 wait cycles -> mem_we_o=1, mem_be_o=0011, fields stable for 4 cycles, dm_valid_o in cycle 4, dm_rdata_o=0.
- Reset mid-access: assert reset_i=0 during BUSY_DM before ready -> next cycle mem_req_o=0, no dm_valid_o, counters 0; after release a new if_req_i is granted normally.
- Timeout (MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): fetch with mem_ready_i held 0 -> if_valid_o=1 and bus_err_o=1 in the 8th BUSY cycle, if_rdata_o=0; repeat with ready on exactly that cycle -> no error.
- Back-to-back fetches only: if_req_i held, ready always high -> if_valid_o every 2nd cycle, mem_req_o alternates 1/0.
